// File: rtl/pipe_buf_memwb_p.sv
// Parametrised MEM/WB pipeline buffer: DEPTH stages with stall, flush, valid tracking and occupancy.
// Optional stall-cycle counter on the StallCnt port when STALL_CNT_EN is defined.
module pipe_buf_memwb_p #(
    parameter int unsigned S     = 15,
    parameter int unsigned B     = 7,
    parameter int unsigned F     = 3,
    parameter int unsigned C     = 3,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned CW    = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [S:0]   InWord,
    input  logic [B:0]   InByte,
    input  logic [C:0]   InCtrl,
    input  logic [F:0]   ForwardIn,
    input  logic         Stall,
    input  logic         Flush,
    output logic [S:0]   OutWord,
    output logic [B:0]   OutByte,
    output logic [F:0]   ForwardOut,
    output logic [C:0]   WB,
    output logic         OutValid,
    output logic [2:0]   Occ
`ifdef STALL_CNT_EN
    ,
    output logic [CW:0]  StallCnt
`endif
);

    localparam int unsigned OCC_W = 3;

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_buf_memwb_p: DEPTH must be in 1..4");
        end
    endgenerate

    logic [S:0]       word_q [DEPTH];
    logic [B:0]       byte_q [DEPTH];
    logic [F:0]       fwd_q  [DEPTH];
    logic [C:0]       ctrl_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_valid;

    // A zero control field marks a bubble.
    assign in_valid = |InCtrl;

    // Valid bits and occupancy after a load edge.
    always_comb begin
        valid_d = valid_q;
        for (int k = int'(DEPTH) - 1; k > 0; k--) begin
            valid_d[k] = valid_q[k-1];
        end
        valid_d[0] = in_valid;
        occ_d = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || Flush) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                word_q[k] <= '0;
                byte_q[k] <= '0;
                fwd_q[k]  <= '0;
                ctrl_q[k] <= '0;
            end
            valid_q <= '0;
            occ_q   <= '0;
        end else if (!Stall) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                word_q[k] <= word_q[k-1];
                byte_q[k] <= byte_q[k-1];
                fwd_q[k]  <= fwd_q[k-1];
                ctrl_q[k] <= ctrl_q[k-1];
            end
            word_q[0] <= in_valid ? InWord    : '0;
            byte_q[0] <= in_valid ? InByte    : '0;
            fwd_q[0]  <= in_valid ? ForwardIn : '0;
            ctrl_q[0] <= InCtrl;
            valid_q   <= valid_d;
            occ_q     <= occ_d;
        end
    end

    assign OutWord    = word_q[DEPTH-1];
    assign OutByte    = byte_q[DEPTH-1];
    assign ForwardOut = fwd_q[DEPTH-1];
    assign WB         = ctrl_q[DEPTH-1];
    assign OutValid   = valid_q[DEPTH-1];
    assign Occ        = occ_q;

`ifdef STALL_CNT_EN
    localparam int unsigned CNT_W = CW + 1;

    logic [CW:0] stall_cnt_q;

    // Saturating count of stalled edges; a flush edge is not a stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (Stall && !Flush && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule
